wb_openram_arbiter: RTL and testbench
=====================================

Name: wb_openram_arbiter

Overview:
Parametrised successor to the two-port Wishbone/OpenRAM wrapper. Multiplexes NUM_PORTS Wishbone slave ports onto the single RW port (port 0) of one OpenRAM macro, using a registered round-robin arbiter, so any number of masters can share a macro on one clock domain. Adds per-port write protection and back-to-back grants between ports. Sits between the user-area Wishbone masters and the OpenRAM macro.

Parameters:
NUM_PORTS, 2, number of Wishbone slave ports (1..8)
ADDR_WIDTH, 8, OpenRAM word-address width; Wishbone byte address is ADDR_WIDTH+2 bits
DATA_WIDTH, 32, data width; multiple of 8; SEL_WIDTH = DATA_WIDTH/8 (localparam)
WRITE_EN_MASK, {NUM_PORTS{1'b1}}, bit i=1 lets port i write; bit i=0 makes port i read-only

Ports:
wb_clk_i  in  1  single clock; also drives ram_clk0
wb_rst_i  in  1  synchronous, active-high reset
wbs_stb_i  in  NUM_PORTS  strobe, bit i = port i
wbs_cyc_i  in  NUM_PORTS  cycle
wbs_we_i  in  NUM_PORTS  write enable
wbs_sel_i  in  NUM_PORTS*SEL_WIDTH  byte selects, port i at [i*SEL_WIDTH +: SEL_WIDTH]
wbs_dat_i  in  NUM_PORTS*DATA_WIDTH  write data, packed the same way
wbs_adr_i  in  NUM_PORTS*(ADDR_WIDTH+2)  byte address, packed the same way
wbs_ack_o  out  NUM_PORTS  acknowledge
wbs_dat_o  out  NUM_PORTS*DATA_WIDTH  read data
ram_clk0  out  1  = wb_clk_i
ram_csb0  out  1  active-low chip select
ram_web0  out  1  active-low write enable
ram_wmask0  out  SEL_WIDTH  byte write mask
ram_addr0  out  ADDR_WIDTH  word address = granted adr[ADDR_WIDTH+1:2]
ram_din0  out  DATA_WIDTH  write data to macro
ram_dout0  in  DATA_WIDTH  read data from macro; valid one cycle after the sampling edge

Behaviour:
- Request from port i: req[i] = wbs_stb_i[i] & wbs_cyc_i[i].
- FSM states are IDLE, ACCESS and RESP. The grant index gnt and the last-served pointer last are registered.
- Reset (sync, next edge) sets state=IDLE, gnt=0 and last=NUM_PORTS-1, so port 0 has first priority.
- While reset is held or in IDLE: ram_csb0=1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0, all wbs_ack_o=0, all wbs_dat_o=0.
- IDLE: if any req, pick the first requesting port searching last+1, last+2, ... (mod NUM_PORTS), register gnt, then go to ACCESS. With no req, stay in IDLE.
- ACCESS (one cycle): ram_csb0=0. ram_addr0, ram_din0 and ram_wmask0 come combinationally from port gnt.
  - ram_web0 = ~(we[gnt] & WRITE_EN_MASK[gnt]).
  - If the write is disallowed, the cycle becomes a harmless read: web0=1, wmask0 still driven.
  - The macro samples at the end of this cycle. Next state is RESP; last <= gnt.
- RESP (one cycle): wbs_ack_o[gnt] = req[gnt]. wbs_dat_o for port gnt = ram_dout0 when it is a read (we=0), otherwise 0. All other ports' ack and dat are 0. ram_csb0=1.
  - Back-to-back: arbitrate among req with bit gnt masked off, searching from gnt+1. If a port wins, register the new gnt and go to ACCESS; otherwise go to IDLE.
- Latency:
  - Request in IDLE at cycle N: csb0 low in N+1, ack in N+2.
  - Sustained multi-port traffic: one access every 2 cycles.
  - A single port re-requesting passes through IDLE: 3 cycles per access.
- Disallowed write (WRITE_EN_MASK[i]=0, we=1): acked normally, RAM contents unchanged, dat_o=0.
- Master drops cyc/stb during ACCESS: the RAM access still happens, but no ack is issued in RESP (ack gated by req[gnt]).
- Reset asserted during ACCESS: the macro still samples that edge (a write completes). Next cycle is IDLE with no ack.
- Reset during RESP: the ack for that cycle is still driven combinationally. The arbiter restarts at port 0.
- NUM_PORTS=1: arbiter degenerates to fixed grant; same timing.
- Only one ack is high in any cycle. ack is never high for a port that is not requesting.

Test Plan:
- Single write then read, port 0: write adr 0x010, dat 0xDEADBEEF, sel 0xF → csb0 low with web0=0, addr0=0x04, ack at cycle+2. Read adr 0x010 → dat_o=0xDEADBEEF with ack at cycle+2.
- Byte mask: write 0x11223344 with sel 0xF, then 0xAABBCCDD with sel 0x5 to the same address → readback 0x11BB33DD.
- Round-robin fairness: NUM_PORTS=4, all ports hold continuous reads → ack order 0,1,2,3,0,…, one ack every 2 cycles, never two acks in the same cycle.
- Write protection: WRITE_EN_MASK=4'b1101, port 1 writes 0xCAFEF00D to addr 0x20 holding 0 → port 1 gets ack, web0 stays 1, readback from port 0 returns 0.
- Abort: port 0 drops cyc in its ACCESS cycle → no ack in RESP; FSM returns to IDLE or serves the next requester.
- Reset mid-traffic: assert wb_rst_i in the RESP of port 2 with ports 0–3 requesting → next cycle csb0=1 and no acks; first grant after release goes to port 0.

Source files
------------

// File: rtl/wb_openram_arbiter.sv
// Round-robin arbiter sharing one OpenRAM RW port among NUM_PORTS Wishbone
// slave ports. Each access is a two-cycle ACCESS/RESP pair. Back-to-back
// grants between different ports are issued from RESP.
module wb_openram_arbiter #(
  parameter int unsigned          NUM_PORTS     = 2,
  parameter int unsigned          ADDR_WIDTH    = 8,
  parameter int unsigned          DATA_WIDTH    = 32,
  parameter logic [NUM_PORTS-1:0] WRITE_EN_MASK = {NUM_PORTS{1'b1}}
) (
  input  logic                                 wb_clk_i,
  input  logic                                 wb_rst_i,
  input  logic [NUM_PORTS-1:0]                 wbs_stb_i,
  input  logic [NUM_PORTS-1:0]                 wbs_cyc_i,
  input  logic [NUM_PORTS-1:0]                 wbs_we_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  wbs_sel_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      wbs_dat_i,
  input  logic [NUM_PORTS*(ADDR_WIDTH+2)-1:0]  wbs_adr_i,
  output logic [NUM_PORTS-1:0]                 wbs_ack_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]      wbs_dat_o,
  output logic                                 ram_clk0,
  output logic                                 ram_csb0,
  output logic                                 ram_web0,
  output logic [DATA_WIDTH/8-1:0]              ram_wmask0,
  output logic [ADDR_WIDTH-1:0]                ram_addr0,
  output logic [DATA_WIDTH-1:0]                ram_din0,
  input  logic [DATA_WIDTH-1:0]                ram_dout0
);

  localparam int unsigned SEL_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned BADR_WIDTH = ADDR_WIDTH + 2;
  localparam int unsigned GW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [GW-1:0]         r_gnt, r_last, w_gnt_nxt, w_last_nxt;
  logic [NUM_PORTS-1:0]  w_req, w_cand, w_rot;
  logic [GW-1:0]         w_base, w_pick;
  logic                  w_pick_valid;

  logic                  w_g_we, w_g_wen;
  logic [SEL_WIDTH-1:0]  w_g_sel;
  logic [DATA_WIDTH-1:0] w_g_dat;
  logic [BADR_WIDTH-1:0] w_g_adr;
  logic [1:0]            w_unused_adr_lsb;

  assign w_req            = wbs_stb_i & wbs_cyc_i;
  assign ram_clk0         = wb_clk_i;
  assign w_unused_adr_lsb = w_g_adr[1:0];

  // Mux the granted port's request fields.
  always_comb begin
    w_g_we  = 1'b0;
    w_g_wen = 1'b0;
    w_g_sel = '0;
    w_g_dat = '0;
    w_g_adr = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (r_gnt == GW'(i)) begin
        w_g_we  = wbs_we_i[i];
        w_g_wen = WRITE_EN_MASK[i];
        w_g_sel = wbs_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
        w_g_dat = wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_g_adr = wbs_adr_i[i*BADR_WIDTH +: BADR_WIDTH];
      end
    end
  end

  // Round-robin pick: rotate the candidate vector so bit 0 is the port after
  // the base, then take the first set bit. In RESP the current grant is masked.
  always_comb begin
    w_cand = w_req;
    if (r_state == S_RESP) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (r_gnt == GW'(i)) w_cand[i] = 1'b0;
      end
    end
    w_base       = (r_state == S_RESP) ? r_gnt : r_last;
    w_rot        = NUM_PORTS'(({w_cand, w_cand} >> w_base) >> 1);
    w_pick_valid = 1'b0;
    w_pick       = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!w_pick_valid && w_rot[k]) begin
        w_pick_valid = 1'b1;
        w_pick       = GW'((32'(w_base) + k + 1) % NUM_PORTS);
      end
    end
  end

  // Next-state logic for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_RESP;
        w_last_nxt  = r_gnt;
      end
      S_RESP: begin
        if (w_pick_valid) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Macro and Wishbone outputs decoded from the current state.
  always_comb begin
    ram_csb0   = 1'b1;
    ram_web0   = 1'b1;
    ram_wmask0 = '0;
    ram_addr0  = '0;
    ram_din0   = '0;
    wbs_ack_o  = '0;
    wbs_dat_o  = '0;
    case (r_state)
      S_ACCESS: begin
        ram_csb0   = 1'b0;
        ram_web0   = ~(w_g_we & w_g_wen);
        ram_wmask0 = w_g_sel;
        ram_addr0  = w_g_adr[ADDR_WIDTH+1:2];
        ram_din0   = w_g_dat;
      end
      S_RESP: begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (r_gnt == GW'(i)) begin
            wbs_ack_o[i] = w_req[i];
            if (!wbs_we_i[i]) wbs_dat_o[i*DATA_WIDTH +: DATA_WIDTH] = ram_dout0;
          end
        end
      end
      default: ;
    endcase
  end

  // State, grant and last-served registers; reset gives port 0 first priority.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_last  <= GW'(NUM_PORTS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// Randomized and directed bench for wb_openram_arbiter with four ports and
// port 1 write-protected. A transaction-level model predicts grants, timing
// and data from the round-robin rules and a shadow memory.
module tb_wb_openram_arbiter;

  localparam int NP = 4;
  localparam logic [3:0] WEM = 4'b1101;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   stb, cyc, we, ack;
  logic [15:0]  sel;
  logic [127:0] dat_i, dat_o;
  logic [39:0]  adr;
  logic         ram_clk, csb, web;
  logic [3:0]   wmask;
  logic [7:0]   raddr;
  logic [31:0]  din, dout;

  always #5 clk = ~clk;

  wb_openram_arbiter #(
    .NUM_PORTS(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .WRITE_EN_MASK(4'b1101)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .ram_clk0(ram_clk), .ram_csb0(csb), .ram_web0(web), .ram_wmask0(wmask),
    .ram_addr0(raddr), .ram_din0(din), .ram_dout0(dout)
  );

  // OpenRAM-like macro: samples on the edge, read data appears after it.
  logic [31:0] ram [256];
  logic        ram_clr;
  always @(posedge ram_clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) ram[raddr][8*b +: 8] <= din[8*b +: 8];
      end else begin
        dout <= ram[raddr];
      end
    end
  end

  typedef struct {
    int          port;
    int unsigned acc_t;
    int unsigned resp_t;
    logic        we_eff;
    logic [7:0]  word;
    logic [31:0] din;
    logic [3:0]  sel;
    logic [31:0] rdata;
  } txn_t;

  int          n_checks, n_errors;
  int unsigned cycle;
  logic        tb_rst;
  logic        m_act [4], m_keep [4], m_we [4];
  logic [9:0]  m_adr [4];
  logic [31:0] m_dat [4];
  logic [3:0]  m_sel [4];
  logic        got_ack [4];
  logic [31:0] got_dat [4];
  int          last_ack_p;
  logic [31:0] shadow [256];
  txn_t        pend [$];
  int unsigned m_last, m_free;
  bit          m_en;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int unsigned after, input int excl);
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = int'((after + k) % NP);
      if (r[p] && p != excl) return p;
    end
    return -1;
  endfunction

  // Predict this cycle's outputs, then decide whether a new grant starts.
  task automatic model_cycle();
    logic [3:0]   req_now, e_ack, e_wmask, wem_v;
    logic [127:0] e_dat;
    logic         e_csb, e_web;
    logic [7:0]   e_addr;
    logic [31:0]  e_din;
    int           excl, w;
    txn_t         t, keep_q [$];
    req_now = stb & cyc;
    wem_v   = WEM;
    e_ack = '0; e_dat = '0; e_csb = 1'b1; e_web = 1'b1;
    e_wmask = '0; e_addr = '0; e_din = '0;
    excl = -1;
    foreach (pend[i]) begin
      if (pend[i].acc_t == cycle) begin
        e_csb = 1'b0; e_web = !pend[i].we_eff; e_wmask = pend[i].sel;
        e_addr = pend[i].word; e_din = pend[i].din;
      end
      if (pend[i].resp_t == cycle) begin
        excl = pend[i].port;
        e_ack[pend[i].port] = req_now[pend[i].port];
        if (!we[pend[i].port]) e_dat[pend[i].port*32 +: 32] = pend[i].rdata;
      end
    end
    if (m_en) begin
      check_eq("ack", ack, e_ack);
      check_eq("dat_o", dat_o, e_dat);
      check_eq("csb0", csb, e_csb);
      check_eq("web0", web, e_web);
      check_eq("wmask0", wmask, e_wmask);
      check_eq("addr0", raddr, e_addr);
      check_eq("din0", din, e_din);
    end
    if (!rst && cycle >= m_free) begin
      w = rr_pick(req_now, m_last, excl);
      if (w >= 0) begin
        t.port = w; t.acc_t = cycle + 1; t.resp_t = cycle + 2;
        t.word = m_adr[w][9:2]; t.din = m_dat[w]; t.sel = m_sel[w];
        t.we_eff = m_we[w] & wem_v[w];
        t.rdata = shadow[t.word];
        if (t.we_eff)
          for (int b = 0; b < 4; b++)
            if (t.sel[b]) shadow[t.word][8*b +: 8] = t.din[8*b +: 8];
        pend.push_back(t);
        m_last = w;
        m_free = cycle + 2;
      end
    end
    if (rst) begin
      pend.delete();
      m_last = NP - 1;
      m_free = cycle + 1;
    end else begin
      foreach (pend[i]) if (pend[i].resp_t > cycle) keep_q.push_back(pend[i]);
      pend = keep_q;
    end
  endtask

  // One clock: drive at posedge+1, check and record at negedge.
  task automatic step();
    @(posedge clk); #1;
    rst = tb_rst;
    for (int p = 0; p < NP; p++) begin
      stb[p] = m_act[p]; cyc[p] = m_act[p]; we[p] = m_we[p];
      sel[p*4 +: 4] = m_sel[p]; dat_i[p*32 +: 32] = m_dat[p]; adr[p*10 +: 10] = m_adr[p];
    end
    @(negedge clk);
    model_cycle();
    last_ack_p = -1;
    for (int p = 0; p < NP; p++) begin
      if (ack[p]) begin
        got_ack[p] = 1'b1;
        got_dat[p] = dat_o[p*32 +: 32];
        last_ack_p = p;
        if (!m_keep[p]) m_act[p] = 1'b0;
      end
    end
    cycle++;
  endtask

  task automatic drain(input int n);
    for (int p = 0; p < NP; p++) begin m_act[p] = 1'b0; m_keep[p] = 1'b0; end
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm(input int p, input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    m_we[p] = w; m_adr[p] = a; m_dat[p] = d; m_sel[p] = s;
    got_ack[p] = 1'b0; m_act[p] = 1'b1;
  endtask

  task automatic xfer(input int p, input logic w, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
    arm(p, w, a, d, s);
    for (int i = 0; i < 20 && !got_ack[p]; i++) step();
    check_eq("xfer_ack", got_ack[p], 1'b1);
    rd = got_dat[p];
  endtask

  // Access from an idle arbiter: chip select one cycle later, ack two later.
  task automatic timed_xfer(input int p, input logic w, input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    logic       e_web;
    logic [3:0] e_ack;
    e_web = !w;
    e_ack = '0;
    e_ack[p] = 1'b1;
    arm(p, w, a, d, s);
    step();
    step();
    check_eq("lat_csb", csb, 1'b0);
    check_eq("lat_web", web, e_web);
    check_eq("lat_addr", raddr, a[9:2]);
    step();
    check_eq("lat_ack", ack, e_ack);
  endtask

  initial begin
    logic [31:0] rd;
    int ap [$];
    int ac [$];
    n_checks = 0; n_errors = 0; cycle = 0;
    m_en = 1'b0; m_last = NP - 1; m_free = 0;
    tb_rst = 1'b1; ram_clr = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    for (int p = 0; p < NP; p++) begin
      m_act[p] = 1'b0; m_keep[p] = 1'b0; m_we[p] = 1'b0; m_adr[p] = '0;
      m_dat[p] = '0; m_sel[p] = '0; got_ack[p] = 1'b0; got_dat[p] = '0;
    end

    step();
    m_en = 1'b1;
    step();
    check_eq("rst_ack", ack, 4'b0000);
    check_eq("rst_csb", csb, 1'b1);
    check_eq("rst_dat", dat_o, 128'h0);
    step();
    tb_rst = 1'b0; ram_clr = 1'b0;
    drain(3);

    timed_xfer(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    timed_xfer(0, 1'b0, 10'h010, 32'h0, 4'hF);
    check_eq("t1_rdata", got_dat[0], 32'hDEADBEEF);

    xfer(0, 1'b1, 10'h040, 32'h11223344, 4'hF, rd);
    xfer(0, 1'b1, 10'h040, 32'hAABBCCDD, 4'h5, rd);
    xfer(0, 1'b0, 10'h040, 32'h0, 4'hF, rd);
    check_eq("bytemask", rd, 32'h11BB33DD);

    xfer(1, 1'b1, 10'h080, 32'hCAFEF00D, 4'hF, rd);
    check_eq("wprot_dat", rd, 32'h0);
    xfer(0, 1'b0, 10'h080, 32'h0, 4'hF, rd);
    check_eq("wprot_rd", rd, 32'h0);

    drain(3);
    for (int p = 0; p < NP; p++) begin
      arm(p, 1'b0, 10'(p * 4), 32'h0, 4'hF);
      m_keep[p] = 1'b1;
    end
    for (int i = 0; i < 60 && ap.size() < 12; i++) begin
      step();
      if (last_ack_p >= 0) begin ap.push_back(last_ack_p); ac.push_back(int'(cycle)); end
    end
    check_eq("fair_count", ap.size(), 12);
    for (int k = 1; k < ap.size(); k++) begin
      check_eq("fair_order", ap[k], (ap[k-1] + 1) % NP);
      check_eq("fair_gap", ac[k] - ac[k-1], 2);
    end

    for (int i = 0; i < 20 && last_ack_p != 1; i++) step();
    check_eq("rst_seek_p1", last_ack_p, 1);
    step();
    tb_rst = 1'b1;
    step();
    check_eq("rst_resp_ack", ack, 4'b0100);
    tb_rst = 1'b0;
    step();
    check_eq("rst_after_csb", csb, 1'b1);
    check_eq("rst_after_ack", ack, 4'b0000);
    last_ack_p = -1;
    for (int i = 0; i < 10 && last_ack_p < 0; i++) step();
    check_eq("rst_first_gnt", last_ack_p, 0);
    drain(4);

    arm(0, 1'b0, 10'h010, 32'h0, 4'hF);
    step();
    m_act[0] = 1'b0;
    arm(3, 1'b0, 10'h040, 32'h0, 4'hF);
    step();
    step();
    check_eq("abort_ack", ack[0], 1'b0);
    for (int i = 0; i < 6 && !got_ack[3]; i++) step();
    check_eq("abort_next", got_ack[3], 1'b1);
    drain(3);

    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!m_act[p] && $urandom_range(0, 1) == 1)
          arm(p, 1'($urandom_range(0, 1)), {4'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
              $urandom, 4'($urandom));
      end
      tb_rst = ($urandom_range(0, 99) == 0);
      step();
    end
    tb_rst = 1'b0;
    drain(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
